pht_update_unit: RTL and testbench
==================================

Name: pht_update_unit

Overview:
- Execute-side writer for the per-address two-level branch predictor's pattern history table (PHT) and local-history recovery path.
- Accepts up to PORT_NUM resolved branch results per cycle from the integer pipes and buffers them in an in-order queue.
- Computes saturating-counter write data and issues PHT writes without same-bank collisions; emits local-history repair on conditional mispredicts.
- Owns the post-reset PHT initialization sweep.

Parameters:
PORT_NUM, 2, result input lanes and PHT write ports (matches INT_ISSUE_WIDTH)
QUEUE_DEPTH, 8, result queue entries (power of two)
INDEX_WIDTH, 10, PHT index bits
HIST_WIDTH, 4, local history bits; counters per entry = 2^HIST_WIDTH
CTR_WIDTH, 2, saturating counter bits
HIST_INDEX_WIDTH, 4, history-table index bits
HIST_OFFSET, 0, extra address shift for the history index

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  PORT_NUM  result valid per lane
in_addr  in  PORT_NUM*32  branch PC per lane
in_taken  in  PORT_NUM  resolved direction
in_is_cond  in  PORT_NUM  conditional branch
in_mispred  in  PORT_NUM  mispredicted
in_hist  in  PORT_NUM*HIST_WIDTH  history snapshot used at prediction
in_entry  in  PORT_NUM*2^HIST_WIDTH*CTR_WIDTH  PHT entry snapshot read at prediction
in_ready  out  1  queue can accept PORT_NUM results this cycle
pht_we  out  PORT_NUM  PHT write enable per port
pht_wa  out  PORT_NUM*INDEX_WIDTH  PHT write index
pht_wv  out  PORT_NUM*2^HIST_WIDTH*CTR_WIDTH  PHT write data
hist_fix_valid  out  PORT_NUM  history repair strobe
hist_fix_index  out  PORT_NUM*HIST_INDEX_WIDTH  history table index
hist_fix_value  out  PORT_NUM*HIST_WIDTH  corrected history
init_busy  out  1  initialization sweep in progress
overflow  out  1  sticky: a valid result arrived while in_ready=0

Behaviour:
- One clock (clk); rst is synchronous, active-high.
- Reset:
  - rst high at an edge: state<=INIT, sweep index<=0, queue emptied (head=tail=count=0), overflow<=0.
  - Outputs during and after reset: pht_we=0 except the port-0 sweep write; hist_fix_valid=0; in_ready=0; init_busy=1.
- States:
  - INIT: port 0 writes pht_wa=sweep index, pht_wv=every counter at 2^(CTR_WIDTH-1) (weakly taken). Other ports idle. Index increments each cycle.
  - INIT to RUN: when index = 2^INDEX_WIDTH-1 is written and rst is low. If rst is still high, the index wraps to 0 and the sweep continues.
  - RUN: normal queue operation.
  - Reset asserted in RUN discards all queued results and restarts the sweep at 0.
- Enqueue (RUN only):
  - in_ready = (count <= QUEUE_DEPTH-PORT_NUM), from registered count.
  - When in_ready=1, valid lanes are written in lane order (lane 0 first) into consecutive slots at the edge.
  - Any in_valid while in_ready=0 is dropped and sets overflow (sticky until rst).
- Issue: combinational from the queue head, so an entry enqueued at edge N is issued no earlier than cycle N+1.
  - Head entry k=0 always issues on port 0 if present.
  - Entry k=1 issues on port 1 only if present and its bank (index bit 0) differs from entry 0's. Otherwise it waits for the next cycle; order is preserved.
  - Issued entries are popped at the same edge. Simultaneous push and pop in one cycle is allowed; count is updated by (pushed - popped).
- Write data for issued entry e:
  - PHT index = addr[INDEX_WIDTH+1:2].
  - pht_wv = snapshot entry with counter[hist] incremented if taken, decremented if not, saturating at 2^CTR_WIDTH-1 and 0.
  - All other counters are copied unchanged.
- History repair:
  - hist_fix_valid[p] = issued & mispred & is_cond.
  - hist_fix_index = addr[HIST_INDEX_WIDTH+1+HIST_OFFSET : 2+HIST_OFFSET].
  - hist_fix_value = {hist[HIST_WIDTH-2:0], taken}.
- Wrap-around: head and tail are log2(QUEUE_DEPTH)-bit pointers that wrap naturally; count is log2(QUEUE_DEPTH)+1 bits.

Decomposition:
- Shared package: the result record typedef (addr, taken, is_cond, mispred, hist, entry), the PHT entry typedef (counter array), and the index/history extraction functions.
- Counter width and weakly-taken constant go there too, next to the existing fetch-unit types.
- One sub-module: pht_counter_update. It is combinational: takes an entry, a history value and a taken bit, and returns the saturated entry. Instantiated PORT_NUM times.

Test Plan:
- Reset then idle, INDEX_WIDTH=4 override -> 16 consecutive port-0 writes, indices 0..15, every counter 2'b10; init_busy falls on cycle 17; in_ready rises.
- Lane0 addr 0x100, hist 3, counter[3]=3, taken -> next cycle pht_wa=0x040, counter[3]=3 (saturated), other counters unchanged; no hist_fix.
- Lane0 0x100 and lane1 0x108 in the same cycle (both bank 0) -> port 0 writes 0x040 in cycle N+1; port 1 idle; 0x042 writes on port 0 in N+2.
- Mispredicted conditional, addr 0x10C, hist 4'b1010, not taken -> hist_fix_valid, index 3, value 4'b0100; counter[10] decremented.
- Fill the queue with bank conflicts until in_ready=0, then drive in_valid -> overflow=1 and sticky; the queue drains in order with no lost earlier entries.
- rst asserted with 5 entries queued -> no further result writes; sweep restarts at index 0; queue empty afterwards.

Source files
------------

// File: rtl/pht_update_unit_pkg.sv
// Shared types for the two-level branch predictor: PHT entry layout, resolved-branch record,
// and the address-to-index extraction helpers used by the execute-side PHT writer.
package pht_update_unit_pkg;

  localparam int HIST_WIDTH  = 4;
  localparam int CTR_WIDTH   = 2;
  localparam int CTR_NUM     = 1 << HIST_WIDTH;
  localparam int ENTRY_WIDTH = CTR_NUM * CTR_WIDTH;

  localparam logic [CTR_WIDTH-1:0] CTR_WEAK_TAKEN = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX        = '1;

  typedef logic [CTR_WIDTH-1:0] phtCtr_t;
  typedef phtCtr_t [CTR_NUM-1:0] phtEntry_t;

  typedef struct packed {
    logic [31:0]           addr;
    logic                  taken;
    logic                  isCond;
    logic                  mispred;
    logic [HIST_WIDTH-1:0] hist;
    phtEntry_t             entry;
  } branchResult_t;

  // Callers truncate to their own index width.
  function automatic logic [31:0] phtIndexOf(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  function automatic logic bankOf(input logic [31:0] addr);
    return addr[2];
  endfunction

  function automatic logic [31:0] histIndexOf(input logic [31:0] addr, input int offset);
    return addr >> (2 + offset);
  endfunction

  function automatic logic [HIST_WIDTH-1:0] repairedHist(input logic [HIST_WIDTH-1:0] hist,
                                                         input logic taken);
    return {hist[HIST_WIDTH-2:0], taken};
  endfunction

endpackage

// File: rtl/pht_counter_update.sv
// Combinational saturating update of the one counter selected by the history value;
// zero latency, no flow control -- every other counter passes through untouched.
module pht_counter_update
  import pht_update_unit_pkg::*;
(
  input  phtEntry_t             entry,
  input  logic [HIST_WIDTH-1:0] hist,
  input  logic                  taken,
  output phtEntry_t             newEntry
);

  always_comb begin
    newEntry = entry;
    if (taken) begin
      if (entry[hist] != CTR_MAX) newEntry[hist] = entry[hist] + CTR_WIDTH'(1);
    end else begin
      if (entry[hist] != '0) newEntry[hist] = entry[hist] - CTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pht_update_unit.sv
// PHT writer: queues resolved branches, issues bank-conflict-free writes the cycle after enqueue,
// repairs local history on mispredicts; in_ready drops when PORT_NUM more results might not fit.
module pht_update_unit
  import pht_update_unit_pkg::*;
#(
  parameter int PORT_NUM         = 2,
  parameter int QUEUE_DEPTH      = 8,
  parameter int INDEX_WIDTH      = 10,
  parameter int HIST_INDEX_WIDTH = 4,
  parameter int HIST_OFFSET      = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [PORT_NUM-1:0]                  in_valid,
  input  logic [PORT_NUM*32-1:0]               in_addr,
  input  logic [PORT_NUM-1:0]                  in_taken,
  input  logic [PORT_NUM-1:0]                  in_is_cond,
  input  logic [PORT_NUM-1:0]                  in_mispred,
  input  logic [PORT_NUM*HIST_WIDTH-1:0]       in_hist,
  input  logic [PORT_NUM*ENTRY_WIDTH-1:0]      in_entry,
  output logic                                 in_ready,
  output logic [PORT_NUM-1:0]                  pht_we,
  output logic [PORT_NUM*INDEX_WIDTH-1:0]      pht_wa,
  output logic [PORT_NUM*ENTRY_WIDTH-1:0]      pht_wv,
  output logic [PORT_NUM-1:0]                  hist_fix_valid,
  output logic [PORT_NUM*HIST_INDEX_WIDTH-1:0] hist_fix_index,
  output logic [PORT_NUM*HIST_WIDTH-1:0]       hist_fix_value,
  output logic                                 init_busy,
  output logic                                 overflow
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] sweepIdx;
  branchResult_t          queue [QUEUE_DEPTH];
  logic [PTR_W-1:0]       headPtr;
  logic [PTR_W-1:0]       tailPtr;
  logic [CNT_W-1:0]       count;
  logic                   overflowReg;

  branchResult_t    laneRec  [PORT_NUM];
  branchResult_t    headRec  [PORT_NUM];
  phtEntry_t        updEntry [PORT_NUM];
  logic [PTR_W-1:0] pushSlot [PORT_NUM];
  logic [CNT_W-1:0] pushCount;
  logic [CNT_W-1:0] popCount;
  logic [PORT_NUM-1:0] issue;
  logic             runActive;

  // rst gates the RUN path combinationally so a reset cycle never retires queued work.
  assign runActive = (state == RUN) && !rst;
  assign in_ready  = runActive && (count <= CNT_W'(QUEUE_DEPTH - PORT_NUM));
  assign init_busy = (state == INIT) || rst;
  assign overflow  = overflowReg;

  always_comb begin
    pushCount = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      laneRec[p].addr    = in_addr[p*32 +: 32];
      laneRec[p].taken   = in_taken[p];
      laneRec[p].isCond  = in_is_cond[p];
      laneRec[p].mispred = in_mispred[p];
      laneRec[p].hist    = in_hist[p*HIST_WIDTH +: HIST_WIDTH];
      laneRec[p].entry   = in_entry[p*ENTRY_WIDTH +: ENTRY_WIDTH];
      pushSlot[p]        = tailPtr + PTR_W'(pushCount);
      if (in_valid[p]) pushCount = pushCount + CNT_W'(1);
    end
  end

  // An entry issues only if every older candidate issued and none shares its bank.
  always_comb begin
    popCount = '0;
    issue    = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      headRec[k] = queue[headPtr + PTR_W'(k)];
      issue[k]   = runActive && (count > CNT_W'(k));
      for (int j = 0; j < k; j++) begin
        if (!issue[j] || (bankOf(headRec[j].addr) == bankOf(headRec[k].addr))) issue[k] = 1'b0;
      end
      if (issue[k]) popCount = popCount + CNT_W'(1);
    end
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : gCtr
    pht_counter_update uCtr (
      .entry   (headRec[p].entry),
      .hist    (headRec[p].hist),
      .taken   (headRec[p].taken),
      .newEntry(updEntry[p])
    );
  end

  always_comb begin
    pht_we         = '0;
    pht_wa         = '0;
    pht_wv         = '0;
    hist_fix_valid = '0;
    hist_fix_index = '0;
    hist_fix_value = '0;
    if (state == INIT) begin
      pht_we[0]                = 1'b1;
      pht_wa[0 +: INDEX_WIDTH] = sweepIdx;
      pht_wv[0 +: ENTRY_WIDTH] = {CTR_NUM{CTR_WEAK_TAKEN}};
    end else begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (issue[p]) begin
          pht_we[p]                                 = 1'b1;
          pht_wa[p*INDEX_WIDTH +: INDEX_WIDTH]      = INDEX_WIDTH'(phtIndexOf(headRec[p].addr));
          pht_wv[p*ENTRY_WIDTH +: ENTRY_WIDTH]      = updEntry[p];
          if (headRec[p].isCond && headRec[p].mispred) begin
            hist_fix_valid[p] = 1'b1;
            hist_fix_index[p*HIST_INDEX_WIDTH +: HIST_INDEX_WIDTH] =
              HIST_INDEX_WIDTH'(histIndexOf(headRec[p].addr, HIST_OFFSET));
            hist_fix_value[p*HIST_WIDTH +: HIST_WIDTH] =
              repairedHist(headRec[p].hist, headRec[p].taken);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      sweepIdx    <= '0;
      headPtr     <= '0;
      tailPtr     <= '0;
      count       <= '0;
      overflowReg <= 1'b0;
    end else begin
      if (state == INIT) begin
        sweepIdx <= sweepIdx + INDEX_WIDTH'(1);
        if (sweepIdx == '1) state <= RUN;
      end
      headPtr <= headPtr + PTR_W'(popCount);
      tailPtr <= tailPtr + (in_ready ? PTR_W'(pushCount) : PTR_W'(0));
      count   <= count + (in_ready ? pushCount : CNT_W'(0)) - popCount;
      if ((|in_valid) && !in_ready) overflowReg <= 1'b1;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (in_ready) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (in_valid[p]) queue[pushSlot[p]] <= laneRec[p];
      end
    end
  end

endmodule

// File: tb/tb_pht_update_unit.sv
// Directed bench for pht_update_unit: init sweep, write-data vector table,
// bank-conflict issue, queue overflow/drain ordering and reset-with-pending-work.
module tb_pht_update_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid, in_taken, in_is_cond, in_mispred;
  logic [63:0] in_addr;
  logic [7:0]  in_hist;
  logic [63:0] in_entry;
  logic        in_ready;
  logic [1:0]  pht_we;
  logic [15:0] pht_wa;
  logic [63:0] pht_wv;
  logic [1:0]  hist_fix_valid;
  logic [7:0]  hist_fix_index;
  logic [7:0]  hist_fix_value;
  logic        init_busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pht_update_unit #(
    .PORT_NUM(2), .QUEUE_DEPTH(8), .INDEX_WIDTH(8), .HIST_INDEX_WIDTH(4), .HIST_OFFSET(0)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_taken(in_taken), .in_is_cond(in_is_cond),
    .in_mispred(in_mispred), .in_hist(in_hist), .in_entry(in_entry),
    .in_ready(in_ready), .pht_we(pht_we), .pht_wa(pht_wa), .pht_wv(pht_wv),
    .hist_fix_valid(hist_fix_valid), .hist_fix_index(hist_fix_index),
    .hist_fix_value(hist_fix_value), .init_busy(init_busy), .overflow(overflow)
  );

  typedef struct {
    logic [31:0] addr;
    logic        taken;
    logic        isCond;
    logic        mispred;
    logic [3:0]  hist;
    logic [31:0] entry;
    logic [7:0]  expWa;
    logic [31:0] expWv;
    logic        expFix;
    logic [3:0]  expFixIdx;
    logic [3:0]  expFixVal;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    in_valid = '0; in_taken = '0; in_is_cond = '0; in_mispred = '0;
    in_addr = '0; in_hist = '0; in_entry = '0;
  endtask

  task automatic drive(input int lane, input logic [31:0] addr, input logic taken,
                       input logic cond, input logic mis, input logic [3:0] hist,
                       input logic [31:0] entry);
    in_valid[lane]        = 1'b1;
    in_addr[lane*32 +: 32] = addr;
    in_taken[lane]        = taken;
    in_is_cond[lane]      = cond;
    in_mispred[lane]      = mis;
    in_hist[lane*4 +: 4]  = hist;
    in_entry[lane*32 +: 32] = entry;
  endtask

  task automatic checkSweep();
    for (int i = 0; i < 256; i++) begin
      #4;
      check("sweep_we", 64'(pht_we), 64'h1);
      check("sweep_wa", 64'(pht_wa[7:0]), 64'(i));
      check("sweep_wv", 64'(pht_wv[31:0]), 64'hAAAAAAAA);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned expQ[$];
    int cyc;
    int tag;
    bit dropDone;

    vecs[0] = '{32'h100,      1'b1, 1'b1, 1'b0, 4'd3,    32'hE4E4E4C4, 8'h40, 32'hE4E4E4C4, 1'b0, 4'h0, 4'h0};
    vecs[1] = '{32'h10C,      1'b0, 1'b1, 1'b1, 4'b1010, 32'hAAAAAAAA, 8'h43, 32'hAA9AAAAA, 1'b1, 4'h3, 4'b0100};
    vecs[2] = '{32'h004,      1'b0, 1'b0, 1'b1, 4'd0,    32'h00000000, 8'h01, 32'h00000000, 1'b0, 4'h0, 4'h0};
    vecs[3] = '{32'h3FC,      1'b1, 1'b1, 1'b1, 4'hF,    32'h40000000, 8'hFF, 32'h80000000, 1'b1, 4'hF, 4'hF};
    vecs[4] = '{32'h12345678, 1'b1, 1'b1, 1'b1, 4'd5,    32'h00000000, 8'h9E, 32'h00000400, 1'b1, 4'hE, 4'hB};
    vecs[5] = '{32'h008,      1'b1, 1'b1, 1'b0, 4'd1,    32'hFFFFFFFF, 8'h02, 32'hFFFFFFFF, 1'b0, 4'h0, 4'h0};

    // Reset and init sweep
    clearInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_init_busy", 64'(init_busy), 64'h1);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_pht_we", 64'(pht_we), 64'h1);
    check("rst_pht_wa", 64'(pht_wa[7:0]), 64'h0);
    check("rst_hist_fix", 64'(hist_fix_valid), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    rst = 1'b0;
    checkSweep();
    #4;
    check("run_init_busy", 64'(init_busy), 64'h0);
    check("run_in_ready", 64'(in_ready), 64'h1);
    check("run_idle_we", 64'(pht_we), 64'h0);

    // Single-lane write-data vectors
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      clearInputs();
      drive(0, vecs[i].addr, vecs[i].taken, vecs[i].isCond, vecs[i].mispred, vecs[i].hist, vecs[i].entry);
      #4;
      check("vec_no_early_issue", 64'(pht_we), 64'h0);
      @(posedge clk); #1;
      clearInputs();
      #4;
      check("vec_we", 64'(pht_we), 64'h1);
      check("vec_wa", 64'(pht_wa[7:0]), 64'(vecs[i].expWa));
      check("vec_wv", 64'(pht_wv[31:0]), 64'(vecs[i].expWv));
      check("vec_fix_valid", 64'(hist_fix_valid), 64'(vecs[i].expFix));
      check("vec_fix_index", 64'(hist_fix_index[3:0]), 64'(vecs[i].expFixIdx));
      check("vec_fix_value", 64'(hist_fix_value[3:0]), 64'(vecs[i].expFixVal));
    end

    // Same-bank pair serialises on port 0
    @(posedge clk); #1;
    clearInputs();
    drive(0, 32'h100, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0);
    drive(1, 32'h108, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0);
    @(posedge clk); #1;
    clearInputs();
    #4;
    check("conf_c1_we", 64'(pht_we), 64'h1);
    check("conf_c1_wa0", 64'(pht_wa[7:0]), 64'h40);
    @(posedge clk); #5;
    check("conf_c2_we", 64'(pht_we), 64'h1);
    check("conf_c2_wa0", 64'(pht_wa[7:0]), 64'h42);
    @(posedge clk); #5;
    check("conf_c3_we", 64'(pht_we), 64'h0);

    // Different banks issue together; port 1 carries lane 1
    @(posedge clk); #1;
    clearInputs();
    drive(0, 32'h100, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0);
    drive(1, 32'h104, 1'b0, 1'b1, 1'b1, 4'd2, 32'hFFFFFFFF);
    @(posedge clk); #1;
    clearInputs();
    #4;
    check("dual_we", 64'(pht_we), 64'h3);
    check("dual_wa", 64'(pht_wa), 64'h4140);
    check("dual_wv0", 64'(pht_wv[31:0]), 64'h00000001);
    check("dual_wv1", 64'(pht_wv[63:32]), 64'hFFFFFFEF);
    check("dual_fix_valid", 64'(hist_fix_valid), 64'h2);
    check("dual_fix_index1", 64'(hist_fix_index[7:4]), 64'h1);
    check("dual_fix_value1", 64'(hist_fix_value[7:4]), 64'h4);

    // Fill with same-bank pairs until in_ready drops, drive one extra, then drain
    @(posedge clk); #5;
    check("pre_fill_overflow", 64'(overflow), 64'h0);
    cyc = 0; tag = 0; dropDone = 1'b0;
    while (cyc < 60 && !(dropDone && expQ.size() == 0)) begin
      @(posedge clk); #1;
      clearInputs();
      if (!dropDone) begin
        if (in_ready) begin
          drive(0, 32'h200 + 32'(tag) * 8, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0);
          drive(1, 32'h200 + 32'(tag + 1) * 8, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0);
          expQ.push_back(32'h80 + 2 * tag);
          expQ.push_back(32'h80 + 2 * (tag + 1));
          tag += 2;
        end else begin
          drive(0, 32'hFFC, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0);
          dropDone = 1'b1;
        end
      end
      #4;
      if (pht_we[1]) check("fill_port1_idle", 64'(pht_we[1]), 64'h0);
      if (pht_we[0]) begin
        if (expQ.size() == 0) check("fill_unexpected_write", 64'(pht_wa[7:0]), 64'hFFFF);
        else check("fill_order_wa0", 64'(pht_wa[7:0]), 64'(expQ.pop_front()));
      end
      cyc++;
    end
    check("fill_drained", 64'(expQ.size()), 64'h0);
    check("fill_accepted_count", 64'(tag), 64'd12);
    check("fill_overflow_sticky", 64'(overflow), 64'h1);
    check("fill_ready_after_drain", 64'(in_ready), 64'h1);

    // Reset with five entries queued
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      clearInputs();
      drive(0, 32'h400 + 32'(2 * c) * 8, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0);
      drive(1, 32'h400 + 32'(2 * c + 1) * 8, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0);
    end
    @(posedge clk); #1;
    clearInputs();
    rst = 1'b1;
    #4;
    check("rstq_no_write", 64'(pht_we), 64'h0);
    check("rstq_in_ready", 64'(in_ready), 64'h0);
    check("rstq_init_busy", 64'(init_busy), 64'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstq_overflow_clr", 64'(overflow), 64'h0);
    checkSweep();
    #4;
    check("rstq_run_ready", 64'(in_ready), 64'h1);
    check("rstq_run_busy", 64'(init_busy), 64'h0);
    for (int c = 0; c < 3; c++) begin
      check("rstq_queue_empty", 64'(pht_we), 64'h0);
      @(posedge clk); #5;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
